// File: rtl/lsu_dtag_wrgen_pkg.sv
// Shared definitions for the L1 D-cache tag array write and read paths.
package lsu_dtag_wrgen_pkg;

  localparam int TAG_W = 29;
  localparam int IDX_W = 7;
  localparam int WAYS  = 4;
  localparam int NGRP  = 4;

  // Parity group bounds; the read-side checker uses the same groups
  localparam int GRP0_LO = 0;
  localparam int GRP0_HI = 7;
  localparam int GRP1_LO = 8;
  localparam int GRP1_HI = 15;
  localparam int GRP2_LO = 16;
  localparam int GRP2_HI = 23;
  localparam int GRP3_LO = 24;
  localparam int GRP3_HI = 28;

  typedef enum logic [1:0] {FL_IDLE, FL_WALK, FL_DONE} flush_st_e;

  typedef enum logic [2:0] {GNT_NONE, GNT_FLUSH, GNT_INV, GNT_FILL, GNT_DIAG} gnt_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       way;
    logic [TAG_W-1:0] tag;
  } fill_req_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  wmask;
  } inv_req_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       way;
    logic [TAG_W-1:0] tag;
    logic             vbit;
    logic             par_flip;
  } diag_req_t;

  // Bit mask selecting the tag bits covered by parity group g
  function automatic logic [TAG_W-1:0] grp_mask(input int g);
    int lo;
    int hi;
    case (g)
      0:       begin lo = GRP0_LO; hi = GRP0_HI; end
      1:       begin lo = GRP1_LO; hi = GRP1_HI; end
      2:       begin lo = GRP2_LO; hi = GRP2_HI; end
      default: begin lo = GRP3_LO; hi = GRP3_HI; end
    endcase
    for (int b = 0; b < TAG_W; b++) grp_mask[b] = (b >= lo) && (b <= hi);
  endfunction

  function automatic logic [WAYS-1:0] way_onehot(input logic [1:0] way);
    way_onehot = '0;
    way_onehot[way] = 1'b1;
  endfunction

endpackage

// File: rtl/lsu_dtag_pargen.sv
// Tag to per-group parity; shared by the write generator and the read checker.
module lsu_dtag_pargen
  import lsu_dtag_wrgen_pkg::*;
(
  input  logic [TAG_W-1:0] tag,
  output logic [NGRP-1:0]  grp_par
);

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign grp_par[g] = ^(tag & grp_mask(g));
  end

endmodule

// File: rtl/lsu_dtag_wrgen.sv
// D-cache tag/valid array write generator: request buffers, flush walk,
// fixed-priority grant around read stalls, registered array strobes.
module lsu_dtag_wrgen
  import lsu_dtag_wrgen_pkg::*;
(
  input  logic               rclk,
  input  logic               arst_l,
  input  logic               fill_vld,
  output logic               fill_rdy,
  input  logic [IDX_W-1:0]   fill_idx,
  input  logic [1:0]         fill_way,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               inv_vld,
  output logic               inv_rdy,
  input  logic [IDX_W-1:0]   inv_idx,
  input  logic [WAYS-1:0]    inv_wmask,
  input  logic               diag_vld,
  output logic               diag_rdy,
  input  logic [IDX_W-1:0]   diag_idx,
  input  logic [1:0]         diag_way,
  input  logic [TAG_W-1:0]   diag_tag,
  input  logic               diag_vbit,
  input  logic               diag_par_flip,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  input  logic               wr_stall,
  output logic               dtag_wr_en,
  output logic [IDX_W-1:0]   dtag_wr_idx,
  output logic [WAYS-1:0]    dtag_wr_way,
  output logic [TAG_W:0]     dtag_wdata,
  output logic               dva_wr_en,
  output logic [IDX_W-1:0]   dva_wr_idx,
  output logic [WAYS-1:0]    dva_wr_mask,
  output logic [WAYS-1:0]    dva_wdata
);

  logic             fill_bv, inv_bv, diag_bv;
  fill_req_t        fill_b;
  inv_req_t         inv_b;
  diag_req_t        diag_b;
  flush_st_e        st, st_nxt;
  logic [IDX_W-1:0] cnt;
  gnt_e             gnt;
  logic [TAG_W-1:0] wtag;
  logic [NGRP-1:0]  grp_par;
  logic             par;

  assign fill_rdy   = ~fill_bv;
  assign inv_rdy    = ~inv_bv;
  assign diag_rdy   = ~diag_bv;
  assign flush_busy = (st == FL_WALK);
  assign flush_done = (st == FL_DONE);

  // Fixed priority grant; the walk owns the port while active, read stall blocks all
  always_comb begin
    gnt = GNT_NONE;
    if (!wr_stall) begin
      if (st == FL_WALK)  gnt = GNT_FLUSH;
      else if (inv_bv)    gnt = GNT_INV;
      else if (fill_bv)   gnt = GNT_FILL;
      else if (diag_bv)   gnt = GNT_DIAG;
    end
  end

  // Flush walk next state
  always_comb begin
    st_nxt = st;
    case (st)
      FL_IDLE: if (flush_req) st_nxt = FL_WALK;
      FL_WALK: if (gnt == GNT_FLUSH && cnt == '1) st_nxt = FL_DONE;
      FL_DONE: st_nxt = FL_IDLE;
      default: st_nxt = FL_IDLE;
    endcase
  end

  // Flush state and set counter
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      st  <= FL_IDLE;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      if (st == FL_IDLE && flush_req) cnt <= '0;
      else if (gnt == GNT_FLUSH)      cnt <= cnt + 1'b1;
    end
  end

  // One-entry holding buffers: load on vld&rdy, drain on grant
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      fill_bv <= 1'b0;
      inv_bv  <= 1'b0;
      diag_bv <= 1'b0;
      fill_b  <= '0;
      inv_b   <= '0;
      diag_b  <= '0;
    end else begin
      if (gnt == GNT_FILL) fill_bv <= 1'b0;
      else if (fill_vld && !fill_bv) begin
        fill_bv <= 1'b1;
        fill_b  <= '{idx: fill_idx, way: fill_way, tag: fill_tag};
      end
      if (gnt == GNT_INV) inv_bv <= 1'b0;
      else if (inv_vld && !inv_bv) begin
        inv_bv <= 1'b1;
        inv_b  <= '{idx: inv_idx, wmask: inv_wmask};
      end
      if (gnt == GNT_DIAG) diag_bv <= 1'b0;
      else if (diag_vld && !diag_bv) begin
        diag_bv <= 1'b1;
        diag_b  <= '{idx: diag_idx, way: diag_way, tag: diag_tag,
                     vbit: diag_vbit, par_flip: diag_par_flip};
      end
    end
  end

  // Only one tag source is granted at a time, so a single parity generator suffices
  assign wtag = (gnt == GNT_DIAG) ? diag_b.tag : fill_b.tag;

  lsu_dtag_pargen u_pargen (
    .tag     (wtag),
    .grp_par (grp_par)
  );

  assign par = (^grp_par) ^ ((gnt == GNT_DIAG) & diag_b.par_flip);

  // Registered array strobes; index/data hold between grants
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      dtag_wr_en  <= 1'b0;
      dtag_wr_idx <= '0;
      dtag_wr_way <= '0;
      dtag_wdata  <= '0;
      dva_wr_en   <= 1'b0;
      dva_wr_idx  <= '0;
      dva_wr_mask <= '0;
      dva_wdata   <= '0;
    end else begin
      dtag_wr_en <= 1'b0;
      dva_wr_en  <= 1'b0;
      case (gnt)
        GNT_FLUSH: begin
          dva_wr_en   <= 1'b1;
          dva_wr_idx  <= cnt;
          dva_wr_mask <= '1;
          dva_wdata   <= '0;
        end
        GNT_INV: begin
          dva_wr_en   <= 1'b1;
          dva_wr_idx  <= inv_b.idx;
          dva_wr_mask <= inv_b.wmask;
          dva_wdata   <= '0;
        end
        GNT_FILL: begin
          dtag_wr_en  <= 1'b1;
          dtag_wr_idx <= fill_b.idx;
          dtag_wr_way <= way_onehot(fill_b.way);
          dtag_wdata  <= {par, fill_b.tag};
          dva_wr_en   <= 1'b1;
          dva_wr_idx  <= fill_b.idx;
          dva_wr_mask <= way_onehot(fill_b.way);
          dva_wdata   <= way_onehot(fill_b.way);
        end
        GNT_DIAG: begin
          dtag_wr_en  <= 1'b1;
          dtag_wr_idx <= diag_b.idx;
          dtag_wr_way <= way_onehot(diag_b.way);
          dtag_wdata  <= {par, diag_b.tag};
          dva_wr_en   <= 1'b1;
          dva_wr_idx  <= diag_b.idx;
          dva_wr_mask <= way_onehot(diag_b.way);
          dva_wdata   <= diag_b.vbit ? way_onehot(diag_b.way) : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dtag_wrgen.sv
// Directed bench for lsu_dtag_wrgen with a valid-array model and flush log.
module tb_lsu_dtag_wrgen;
  import lsu_dtag_wrgen_pkg::*;

  logic               rclk, arst_l;
  logic               fill_vld, fill_rdy;
  logic [IDX_W-1:0]   fill_idx;
  logic [1:0]         fill_way;
  logic [TAG_W-1:0]   fill_tag;
  logic               inv_vld, inv_rdy;
  logic [IDX_W-1:0]   inv_idx;
  logic [WAYS-1:0]    inv_wmask;
  logic               diag_vld, diag_rdy;
  logic [IDX_W-1:0]   diag_idx;
  logic [1:0]         diag_way;
  logic [TAG_W-1:0]   diag_tag;
  logic               diag_vbit, diag_par_flip;
  logic               flush_req, flush_busy, flush_done, wr_stall;
  logic               dtag_wr_en;
  logic [IDX_W-1:0]   dtag_wr_idx;
  logic [WAYS-1:0]    dtag_wr_way;
  logic [TAG_W:0]     dtag_wdata;
  logic               dva_wr_en;
  logic [IDX_W-1:0]   dva_wr_idx;
  logic [WAYS-1:0]    dva_wr_mask, dva_wdata;

  int n_chk = 0;
  int n_err = 0;

  lsu_dtag_wrgen dut (
    .rclk(rclk), .arst_l(arst_l),
    .fill_vld(fill_vld), .fill_rdy(fill_rdy), .fill_idx(fill_idx),
    .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_vld(inv_vld), .inv_rdy(inv_rdy), .inv_idx(inv_idx), .inv_wmask(inv_wmask),
    .diag_vld(diag_vld), .diag_rdy(diag_rdy), .diag_idx(diag_idx), .diag_way(diag_way),
    .diag_tag(diag_tag), .diag_vbit(diag_vbit), .diag_par_flip(diag_par_flip),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wr_stall(wr_stall),
    .dtag_wr_en(dtag_wr_en), .dtag_wr_idx(dtag_wr_idx), .dtag_wr_way(dtag_wr_way),
    .dtag_wdata(dtag_wdata),
    .dva_wr_en(dva_wr_en), .dva_wr_idx(dva_wr_idx), .dva_wr_mask(dva_wr_mask),
    .dva_wdata(dva_wdata)
  );

  // Read-side checker view of the written tag word
  logic [NGRP-1:0] rd_grp;
  logic            rd_perr;
  lsu_dtag_pargen u_rdchk (.tag(dtag_wdata[TAG_W-1:0]), .grp_par(rd_grp));
  assign rd_perr = (^rd_grp) != dtag_wdata[TAG_W];

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // Valid-array model and flush write log, sampled mid-cycle
  logic [WAYS-1:0] vmodel [2**IDX_W];
  int   flog[$];
  bit   log_on = 0;
  int   n_dva = 0, n_done = 0, done_at = -1, bad_fl = 0;

  initial for (int i = 0; i < 2**IDX_W; i++) vmodel[i] = '0;

  always @(negedge rclk) begin
    if (dva_wr_en) begin
      n_dva++;
      vmodel[dva_wr_idx] = (vmodel[dva_wr_idx] & ~dva_wr_mask) | (dva_wdata & dva_wr_mask);
      if (log_on) begin
        flog.push_back(int'(dva_wr_idx));
        if (dva_wr_mask != 4'hF || dva_wdata != 4'h0) bad_fl++;
      end
    end
    if (flush_done) begin
      n_done++;
      done_at = flog.size();
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic run_flush(input bit stall_3rd, input bit mid_req);
    int d0;
    d0 = n_done;
    for (int c = 0; c < 800 && n_done == d0; c++) begin
      wr_stall  = stall_3rd && (c % 3 == 2);
      flush_req = mid_req && (c == 50);
      step(1);
    end
    wr_stall  = 1'b0;
    flush_req = 1'b0;
    step(2);
    chk("flush_no_timeout", 64'(n_done > d0), 64'd1);
  endtask

  initial begin
    int wr0;
    bit seen;
    arst_l = 1'b0;
    fill_vld = 0; fill_idx = '0; fill_way = '0; fill_tag = '0;
    inv_vld = 0; inv_idx = '0; inv_wmask = '0;
    diag_vld = 0; diag_idx = '0; diag_way = '0; diag_tag = '0;
    diag_vbit = 0; diag_par_flip = 0; flush_req = 0; wr_stall = 0;
    step(3);
    // reset state
    chk("rst_dtag_en", 64'(dtag_wr_en), 64'd0);
    chk("rst_dva_en",  64'(dva_wr_en), 64'd0);
    chk("rst_rdy",     64'({fill_rdy, inv_rdy, diag_rdy}), 64'b111);
    chk("rst_flush",   64'({flush_busy, flush_done}), 64'd0);
    chk("rst_wdata",   64'(dtag_wdata), 64'd0);
    arst_l = 1'b1;
    step(2);

    // fill idx5 way2: tag has even parity
    fill_vld = 1; fill_idx = 7'h05; fill_way = 2'd2; fill_tag = 29'h1ABCDEF0;
    step(1);
    fill_vld = 0;
    chk("fill_rdy_low", 64'(fill_rdy), 64'd0);
    chk("fill_no_early", 64'(dtag_wr_en), 64'd0);
    step(1);
    chk("fill_en",    64'(dtag_wr_en), 64'd1);
    chk("fill_idx",   64'(dtag_wr_idx), 64'h05);
    chk("fill_way",   64'(dtag_wr_way), 64'b0100);
    chk("fill_wdata", 64'(dtag_wdata), 64'h1ABCDEF0);
    chk("fill_dva",   64'({dva_wr_en, dva_wr_mask, dva_wdata}), 64'h144);
    chk("fill_rdy_back", 64'(fill_rdy), 64'd1);
    step(1);
    chk("fill_en_drop", 64'({dtag_wr_en, dva_wr_en}), 64'd0);
    chk("fill_hold",  64'(dtag_wdata), 64'h1ABCDEF0);

    // inv and fill to the same line on the same edge
    inv_vld = 1; inv_idx = 7'h05; inv_wmask = 4'hF;
    fill_vld = 1; fill_idx = 7'h05; fill_way = 2'd1; fill_tag = 29'h0000_0003;
    step(1);
    inv_vld = 0; fill_vld = 0;
    step(1);
    chk("inv_first",  64'({dtag_wr_en, dva_wr_en, dva_wr_mask, dva_wdata}), 64'h1F0);
    chk("inv_idx",    64'(dva_wr_idx), 64'h05);
    step(1);
    chk("fill_second", 64'({dtag_wr_en, dtag_wr_way}), 64'h12);
    chk("fill2_wdata", 64'(dtag_wdata), 64'h0000_0003);
    step(1);
    chk("line5_valid", 64'(vmodel[5]), 64'b0010);

    // inv with empty mask still produces a write
    inv_vld = 1; inv_idx = 7'h11; inv_wmask = 4'h0;
    step(1);
    inv_vld = 0;
    step(1);
    chk("inv_zero_mask", 64'({dva_wr_en, dva_wr_idx, dva_wr_mask}), {53'd0, 1'b1, 7'h11, 4'h0});

    // diag with parity flip on a zero tag
    diag_vld = 1; diag_idx = 7'h09; diag_way = 2'd3; diag_tag = '0;
    diag_vbit = 1; diag_par_flip = 1;
    step(1);
    diag_vld = 0;
    step(1);
    chk("diag_wdata", 64'(dtag_wdata), 64'h2000_0000);
    chk("diag_dva",   64'({dtag_wr_way, dva_wr_mask, dva_wdata}), 64'h888);
    chk("diag_perr",  64'(rd_perr), 64'd1);
    step(1);

    // diag with vbit=0, no flip, odd-parity tag
    diag_vld = 1; diag_idx = 7'h0A; diag_way = 2'd0; diag_tag = 29'h155;
    diag_vbit = 0; diag_par_flip = 0;
    step(1);
    diag_vld = 0;
    step(1);
    chk("diag2_wdata", 64'(dtag_wdata), 64'h2000_0155);
    chk("diag2_dva",   64'({dva_wr_en, dva_wr_mask, dva_wdata}), 64'h110);
    chk("diag2_perr",  64'(rd_perr), 64'd0);
    step(1);

    // fill held off by a 10-cycle read stall
    wr_stall = 1;
    fill_vld = 1; fill_idx = 7'h03; fill_way = 2'd0; fill_tag = 29'h1;
    step(1);
    fill_vld = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_no_wr", 64'({dtag_wr_en, dva_wr_en}), 64'd0);
      chk("stall_rdy_low", 64'(fill_rdy), 64'd0);
      step(1);
    end
    wr_stall = 0;
    step(1);
    chk("stall_release", 64'({dtag_wr_en, dtag_wr_way}), 64'h11);
    chk("stall_wdata", 64'(dtag_wdata), 64'h2000_0001);
    step(2);

    // flush walk with a stall every third cycle and a stray flush_req mid-walk
    flog.delete(); log_on = 1; bad_fl = 0;
    flush_req = 1;
    step(1);
    flush_req = 0;
    chk("flush_busy", 64'(flush_busy), 64'd1);
    run_flush(1'b1, 1'b1);
    log_on = 0;
    chk("flush_count", 64'(flog.size()), 64'd128);
    seen = 0;
    for (int i = 0; i < flog.size(); i++) if (flog[i] != i) seen = 1;
    chk("flush_order", 64'(seen), 64'd0);
    chk("flush_data", 64'(bad_fl), 64'd0);
    chk("flush_done_once", 64'(n_done), 64'd1);
    chk("flush_done_after_127", 64'(done_at), 64'd128);
    chk("flush_idle", 64'({flush_busy, flush_done}), 64'd0);
    chk("line5_flushed", 64'(vmodel[5]), 64'd0);

    // reset mid-walk with an inv buffered
    flush_req = 1;
    step(1);
    flush_req = 0;
    inv_vld = 1; inv_idx = 7'h07; inv_wmask = 4'h1;
    step(1);
    inv_vld = 0;
    chk("walk_inv_buffered", 64'(inv_rdy), 64'd0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      seen = dva_wr_en && (dva_wr_idx == 7'd40);
    end
    chk("walk_reach_40", 64'(seen), 64'd1);
    arst_l = 1'b0;
    #1;
    chk("arst_outputs", 64'({dtag_wr_en, dva_wr_en, dva_wr_idx, dtag_wdata}), 64'd0);
    chk("arst_fsm", 64'({flush_busy, flush_done, inv_rdy}), 64'b001);
    step(2);
    arst_l = 1'b1;
    wr0 = n_dva;
    step(10);
    chk("arst_no_writes", 64'(n_dva - wr0), 64'd0);

    // fresh flush restarts from set 0
    flog.delete(); log_on = 1;
    flush_req = 1;
    step(1);
    flush_req = 0;
    run_flush(1'b0, 1'b0);
    log_on = 0;
    chk("reflush_count", 64'(flog.size()), 64'd128);
    chk("reflush_first", 64'(flog.size() > 0 ? flog[0] : -1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
